// File: rtl/rv64_pkg.sv
// rv64_pkg: shared RV64I constants, immediate-format enum and opcode classification helpers.
package rv64_pkg;
  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam int OPC_LSB = 0,  OPC_MSB = 6;
  localparam int RD_LSB  = 7,  RD_MSB  = 11;
  localparam int F3_LSB  = 12, F3_MSB  = 14;
  localparam int RS1_LSB = 15, RS1_MSB = 19;
  localparam int RS2_LSB = 20, RS2_MSB = 24;
  localparam int F7_LSB  = 25, F7_MSB  = 31;
  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} immType_e;
  function automatic immType_e immTypeOf(input logic [6:0] opc);
    return (opc inside {OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32, OPC_JALR}) ? IMM_I :
           (opc == OPC_STORE)                    ? IMM_S :
           (opc == OPC_BRANCH)                   ? IMM_B :
           (opc inside {OPC_LUI, OPC_AUIPC})     ? IMM_U :
           (opc == OPC_JAL)                      ? IMM_J : IMM_NONE;
  endfunction
  function automatic logic isLegal(input logic [6:0] opc);
    return opc inside {OPC_LOAD, OPC_OP_IMM, OPC_AUIPC, OPC_OP_IMM_32, OPC_STORE, OPC_OP,
                       OPC_LUI, OPC_OP_32, OPC_BRANCH, OPC_JALR, OPC_JAL};
  endfunction
  function automatic logic writesRd(input logic [6:0] opc);
    return opc inside {OPC_LOAD, OPC_OP_IMM, OPC_AUIPC, OPC_OP_IMM_32, OPC_OP,
                       OPC_LUI, OPC_OP_32, OPC_JALR, OPC_JAL};
  endfunction
endpackage

// File: rtl/instr_decode_stage_if.sv
// instr_decode_stage_if: upstream handshake, register-file read addresses and decoded downstream bus.
interface instr_decode_stage_if #(parameter int XLEN = rv64_pkg::XLEN, parameter int ILEN = rv64_pkg::ILEN);
  logic            in_valid;
  logic            in_ready;
  logic [ILEN-1:0] in_instr;
  logic [XLEN-1:0] in_pc;
  logic [4:0]      rf_rs1;
  logic [4:0]      rf_rs2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      out_rd;
  logic            out_reg_write;
  logic [6:0]      out_opcode;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [XLEN-1:0] out_imm;
  logic            out_illegal;
  modport master (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, rf_rs1, rf_rs2, out_valid, out_pc, out_rd, out_reg_write,
           out_opcode, out_funct3, out_funct7, out_imm, out_illegal
  );
  modport slave (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, rf_rs1, rf_rs2, out_valid, out_pc, out_rd, out_reg_write,
           out_opcode, out_funct3, out_funct7, out_imm, out_illegal
  );
endinterface

// File: rtl/instr_decode_stage_imm_gen.sv
// imm_gen: sign-extends the immediate of an instruction for a given immediate format.
module imm_gen
  import rv64_pkg::*;
#(
  parameter int XLEN = rv64_pkg::XLEN
) (
  input  logic [31:0]     instr,
  input  immType_e        immType,
  output logic [XLEN-1:0] imm
);
  always_comb
    imm = (immType == IMM_I) ? {{(XLEN-12){instr[31]}}, instr[31:20]} :
          (immType == IMM_S) ? {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]} :
          (immType == IMM_B) ? {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} :
          (immType == IMM_U) ? {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0} :
          (immType == IMM_J) ? {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} :
          '0;
endmodule

// File: rtl/instr_decode_stage.sv
// instr_decode_stage: RV64I decode with a single-entry output register aligned to the register file's registered read.
module instr_decode_stage
  import rv64_pkg::*;
#(
  parameter int XLEN = rv64_pkg::XLEN,
  parameter int ILEN = rv64_pkg::ILEN
) (
  input logic                  clk,
  input logic                  reset,
  instr_decode_stage_if.master bus
);
  logic [ILEN-1:0] instr;
  logic [6:0]      opc;
  logic [XLEN-1:0] imm;
  logic            accept, stalled, legal, regWrite;
  logic [4:0]      heldRs1, heldRs2;
  assign instr        = bus.in_instr;
  assign opc          = instr[OPC_MSB:OPC_LSB];
  assign legal        = isLegal(opc);
  assign regWrite     = writesRd(opc) && instr[RD_MSB:RD_LSB] != 5'd0;
  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign stalled      = bus.out_valid && !bus.out_ready;
  // A stalled instruction keeps its operands re-read so late register writes are seen.
  assign bus.rf_rs1   = stalled ? heldRs1 : instr[RS1_MSB:RS1_LSB];
  assign bus.rf_rs2   = stalled ? heldRs2 : instr[RS2_MSB:RS2_LSB];
  imm_gen #(.XLEN(XLEN)) u_immGen (
    .instr   (instr[31:0]),
    .immType (immTypeOf(opc)),
    .imm     (imm)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      bus.out_valid     <= 1'b0;
      bus.out_pc        <= '0;
      bus.out_rd        <= '0;
      bus.out_reg_write <= 1'b0;
      bus.out_opcode    <= '0;
      bus.out_funct3    <= '0;
      bus.out_funct7    <= '0;
      bus.out_imm       <= '0;
      bus.out_illegal   <= 1'b0;
      heldRs1           <= '0;
      heldRs2           <= '0;
    end else if (accept) begin
      bus.out_valid     <= 1'b1;
      bus.out_pc        <= bus.in_pc;
      bus.out_rd        <= instr[RD_MSB:RD_LSB];
      bus.out_reg_write <= regWrite;
      bus.out_opcode    <= opc;
      bus.out_funct3    <= instr[F3_MSB:F3_LSB];
      bus.out_funct7    <= instr[F7_MSB:F7_LSB];
      bus.out_imm       <= imm;
      bus.out_illegal   <= !legal;
      heldRs1           <= instr[RS1_MSB:RS1_LSB];
      heldRs2           <= instr[RS2_MSB:RS2_LSB];
    end else if (bus.out_ready) begin
      bus.out_valid     <= 1'b0;
    end
endmodule

// File: tb/tb_instr_decode_stage.sv
// tb_instr_decode_stage: table vectors, directed stall/stream/reset sequences and randomized traffic vs a reference model.
module tb_instr_decode_stage;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int nChecks = 0, nFail = 0;
  instr_decode_stage_if bus ();
  instr_decode_stage dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic        rw;
    logic [63:0] imm;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic        rw;
    logic [63:0] imm;
    logic [2:0]  f3;
    logic        ill;
  } vec_t;

  logic        mValid = 1'b0;
  logic [31:0] mInstr = '0;
  logic [63:0] mPc = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t refDecode(input logic [31:0] i);
    exp_t e;
    logic signed [63:0] t;
    logic [6:0] op;
    op = i[6:0];
    e.rd = i[11:7];
    e.imm = '0;
    e.ill = 1'b0;
    case (op)
      7'h03, 7'h13, 7'h1B, 7'h67: begin t = {i[31:20], 52'b0}; e.imm = t >>> 52; end
      7'h23: begin t = {i[31:25], i[11:7], 52'b0}; e.imm = t >>> 52; end
      7'h63: begin t = {i[31], i[7], i[30:25], i[11:8], 1'b0, 51'b0}; e.imm = t >>> 51; end
      7'h37, 7'h17: e.imm = {{32{i[31]}}, i[31:12], 12'b0};
      7'h6F: begin t = {i[31], i[19:12], i[20], i[30:21], 1'b0, 43'b0}; e.imm = t >>> 43; end
      7'h33, 7'h3B: ;
      default: e.ill = 1'b1;
    endcase
    e.rw = !e.ill && op != 7'h23 && op != 7'h63 && i[11:7] != 5'd0;
    return e;
  endfunction

  task automatic checkRegs();
    exp_t e;
    check("out_valid", bus.out_valid, mValid);
    if (mValid) begin
      e = refDecode(mInstr);
      check("out_pc", bus.out_pc, mPc);
      check("out_rd", bus.out_rd, e.rd);
      check("out_reg_write", bus.out_reg_write, e.rw);
      check("out_opcode", bus.out_opcode, mInstr[6:0]);
      check("out_funct3", bus.out_funct3, mInstr[14:12]);
      check("out_funct7", bus.out_funct7, mInstr[31:25]);
      check("out_imm", bus.out_imm, e.imm);
      check("out_illegal", bus.out_illegal, e.ill);
    end
  endtask

  // Called at a negedge; returns at the following negedge with the registered outputs checked.
  task automatic drive(input logic v, input logic [31:0] ins, input logic [63:0] pc, input logic ordy,
                       output logic [4:0] seenRs1, output logic [4:0] seenRs2, output logic seenRdy);
    logic stall, acc;
    bus.in_valid = v;
    bus.in_instr = ins;
    bus.in_pc = pc;
    bus.out_ready = ordy;
    #1;
    stall = mValid && !ordy;
    acc = v && (!mValid || ordy);
    seenRs1 = bus.rf_rs1;
    seenRs2 = bus.rf_rs2;
    seenRdy = bus.in_ready;
    check("in_ready", bus.in_ready, !stall);
    check("rf_rs1", bus.rf_rs1, stall ? mInstr[19:15] : ins[19:15]);
    check("rf_rs2", bus.rf_rs2, stall ? mInstr[24:20] : ins[24:20]);
    @(posedge clk);
    if (acc) begin
      mValid = 1'b1;
      mInstr = ins;
      mPc = pc;
    end else if (ordy) mValid = 1'b0;
    @(negedge clk);
    checkRegs();
  endtask

  task automatic checkCleared(input string tag);
    check({tag, "_valid"}, bus.out_valid, 0);
    check({tag, "_pc"}, bus.out_pc, 0);
    check({tag, "_rd"}, bus.out_rd, 0);
    check({tag, "_imm"}, bus.out_imm, 0);
    check({tag, "_illegal"}, bus.out_illegal, 0);
    check({tag, "_in_ready"}, bus.in_ready, 1);
  endtask

  vec_t vecs[6];
  logic [6:0] opcs[11] = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B};

  initial begin
    logic [4:0] r1, r2;
    logic rdy;
    logic [31:0] rnd, ins;
    logic [63:0] pcs[8];
    vecs[0] = '{32'hFFF08293, 64'h1000, 5'd1, 5'd31, 5'd5, 1'b1, 64'hFFFFFFFFFFFFFFFF, 3'd0, 1'b0};
    vecs[1] = '{32'h0021B423, 64'h1004, 5'd3, 5'd2, 5'd8, 1'b0, 64'd8, 3'd3, 1'b0};
    vecs[2] = '{32'h12345037, 64'h1008, 5'd8, 5'd3, 5'd0, 1'b0, 64'h12345000, 3'd5, 1'b0};
    vecs[3] = '{32'h0000007F, 64'h100C, 5'd0, 5'd0, 5'd0, 1'b0, 64'd0, 3'd0, 1'b1};
    vecs[4] = '{32'hFFDFF0EF, 64'h1010, 5'd31, 5'd29, 5'd1, 1'b1, 64'hFFFFFFFFFFFFFFFC, 3'd7, 1'b0};
    vecs[5] = '{32'h00001863, 64'h1014, 5'd0, 5'd0, 5'd16, 1'b0, 64'd16, 3'd1, 1'b0};
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.in_pc = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checkCleared("reset");
    reset = 1'b0;

    foreach (vecs[k]) begin
      drive(1'b1, vecs[k].instr, vecs[k].pc, 1'b1, r1, r2, rdy);
      check("tbl_rs1", r1, vecs[k].rs1);
      check("tbl_rs2", r2, vecs[k].rs2);
      check("tbl_valid", bus.out_valid, 1);
      check("tbl_rd", bus.out_rd, vecs[k].rd);
      check("tbl_reg_write", bus.out_reg_write, vecs[k].rw);
      check("tbl_imm", bus.out_imm, vecs[k].imm);
      check("tbl_funct3", bus.out_funct3, vecs[k].f3);
      check("tbl_illegal", bus.out_illegal, vecs[k].ill);
    end
    drive(1'b0, 32'h0, 64'h0, 1'b1, r1, r2, rdy);
    check("drain_valid", bus.out_valid, 0);

    drive(1'b1, 32'hFFF08293, 64'h2000, 1'b1, r1, r2, rdy);
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 32'h00338313, 64'h2004, 1'b0, r1, r2, rdy);
      check("stall_in_ready", rdy, 0);
      check("stall_rs1", r1, 1);
      check("stall_pc", bus.out_pc, 64'h2000);
      check("stall_rd", bus.out_rd, 5);
    end
    drive(1'b1, 32'h00338313, 64'h2004, 1'b1, r1, r2, rdy);
    check("release_in_ready", rdy, 1);
    check("release_rs1", r1, 7);
    check("release_pc", bus.out_pc, 64'h2004);
    check("release_rd", bus.out_rd, 6);
    check("release_imm", bus.out_imm, 3);

    for (int k = 0; k < 8; k++) begin
      rnd = $urandom();
      pcs[k] = 64'h3000 + 64'(4 * k);
      drive(1'b1, {rnd[31:7], opcs[k]}, pcs[k], 1'b1, r1, r2, rdy);
      check("stream_valid", bus.out_valid, 1);
      check("stream_pc", bus.out_pc, pcs[k]);
    end

    drive(1'b1, 32'hFFF08293, 64'h4000, 1'b1, r1, r2, rdy);
    drive(1'b0, 32'h0, 64'h0, 1'b0, r1, r2, rdy);
    bus.in_instr = 32'h00338313;
    #2 reset = 1'b1;
    #1;
    mValid = 1'b0;
    checkCleared("async_reset");
    check("async_reset_rs1", bus.rf_rs1, 7);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 32'hFFF08293, 64'h5000, 1'b1, r1, r2, rdy);
    check("post_reset_rs1", r1, 1);
    check("post_reset_rd", bus.out_rd, 5);
    check("post_reset_imm", bus.out_imm, 64'hFFFFFFFFFFFFFFFF);

    for (int c = 0; c < 400; c++) begin
      rnd = $urandom();
      ins = {rnd[31:7], ($urandom_range(0, 3) == 0) ? 7'($urandom()) : opcs[$urandom_range(0, 10)]};
      drive($urandom_range(0, 9) < 7, ins, {$urandom(), $urandom()}, $urandom_range(0, 9) < 6, r1, r2, rdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule

// File: doc/instr_decode_stage.md
Name: instr_decode_stage

Overview:
- RV64I decode stage that sits directly upstream of the 64-bit register file.
- Accepts 32-bit instructions over a valid/ready handshake and drives the register-file read addresses in the cycle an instruction is accepted.
- Registers the decoded control fields and the sign-extended immediate into a single-entry pipeline register. The register file's one-cycle registered read data lines up with this stage's outputs for the execute stage.

Parameters:
- XLEN, 64, datapath width for the PC and the immediate.
- ILEN, 32, instruction width.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept an instruction this cycle
- in_instr  in  ILEN  raw instruction
- in_pc  in  XLEN  PC of in_instr
- rf_rs1  out  5  register-file read address 1 (combinational)
- rf_rs2  out  5  register-file read address 2 (combinational)
- out_valid  out  1  decoded instruction valid
- out_ready  in  1  downstream accepts
- out_pc  out  XLEN  registered PC
- out_rd  out  5  destination register
- out_reg_write  out  1  instruction writes rd (0 when rd==0)
- out_opcode  out  7  instr[6:0]
- out_funct3  out  3  instr[14:12]
- out_funct7  out  7  instr[31:25]
- out_imm  out  XLEN  sign-extended immediate
- out_illegal  out  1  opcode not in the supported RV64I set

Behaviour:
- Reset (async, active-high): out_valid=0. All other registered outputs are 0. A held rs1/rs2 copy is cleared to 0. in_ready=1 one cycle after reset is released.
- in_ready = !out_valid || out_ready. Purely combinational; no dependency on in_valid.
- Accept occurs when in_valid && in_ready. On the next posedge, out_* load the decoded fields and out_valid=1.
- Latency: exactly 1 cycle from accept to out_valid.
- When out_valid && out_ready && !accept: out_valid goes to 0 on the next edge.
- Full throughput: out_ready held high together with in_valid gives 1 instruction/cycle with no bubble.
- Register-file alignment:
  - Normally rf_rs1/rf_rs2 = in_instr[19:15]/[24:20].
  - While out_valid && !out_ready (stalled), rf_rs1/rf_rs2 are driven from the held copy of the registered instruction's rs1/rs2. The register file therefore keeps re-reading the operands of the stalled instruction, and its data stays aligned with out_* and picks up any intervening writes.
  - When the stage is idle with no accept, rf_rs* still follow in_instr; the value is don't-care downstream.
- Immediate, by opcode (all sign-extended from instr[31]):
  - I-type (LOAD 0000011, OP-IMM 0010011, OP-IMM-32 0011011, JALR 1100111): instr[31:20].
  - S-type (STORE 0100011): {instr[31:25], instr[11:7]}.
  - B-type (BRANCH 1100011): {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U-type (LUI 0110111, AUIPC 0010111): {instr[31:12], 12'b0}.
  - J-type (JAL 1101111): {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - R-type (OP 0110011, OP-32 0111011) and illegal: imm=0.
- reg_write = 1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, OP-IMM-32, OP-32, and only when rd != 0.
- Any other opcode: out_illegal=1, reg_write=0, imm=0. The instruction is still passed downstream.
- Simultaneous drain and accept in the same cycle: the new instruction replaces the old one and out_valid stays 1.
- Reset mid-stall: the held instruction is dropped and out_valid=0 immediately (asynchronous).
- No internal FSM beyond the valid bit; the stage never generates a bubble on its own.

Decomposition:
- Shared package rv64_pkg:
  - opcode localparams (OPC_LOAD, OPC_STORE, ...)
  - field position constants
  - XLEN
  - imm-type enum {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE}
- Sub-module imm_gen (combinational: instr in, imm-type in, imm out), reusable by a future branch unit.

Test Plan:
- Single accept, in_instr=0xFFF08293 (addi x5,x1,-1): rf_rs1=1 in the accept cycle. Next cycle: out_valid=1, out_rd=5, out_reg_write=1, out_imm=0xFFFFFFFFFFFFFFFF, out_funct3=0, out_illegal=0.
- in_instr=0x0021B423 (sd x2,8(x3)): rf_rs1=3, rf_rs2=2. Next cycle: out_imm=8, out_reg_write=0, out_funct3=3.
- in_instr=0x12345037 (lui x0): out_imm=0x0000000012345000, out_rd=0, out_reg_write=0. Then in_instr=0x0000007F: out_illegal=1, out_reg_write=0, out_imm=0.
- Backpressure: accept addi x5,x1,-1, then hold out_ready=0 for 3 cycles while in_instr changes to an instruction with rs1=7. Required: in_ready=0, rf_rs1 stays 1, outputs stable. Release out_ready: the next instruction is accepted the same cycle.
- Streaming: 8 back-to-back instructions with out_ready=1. Required: 8 consecutive out_valid cycles, in order, with no bubble, and out_pc matching in_pc delayed by 1.
- Assert reset while out_valid=1 and stalled: out_valid=0 immediately, outputs cleared. After reset is released, in_ready=1 and the first accept behaves as in the single-accept scenario.
